uart_buffered_transmitter: RTL and testbench

//   Parametrised UART transmitter with an input FIFO. Drives the uart_transmit pin of

---
 rtl/uart_buffered_transmitter.sv | 162 ++++++++++++++++
 tb/tb_uart_buffered_transmitter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_buffered_transmitter.sv
// UART transmitter fed from a valid/ready FIFO. While the FIFO holds data,
// frames go out back to back with no idle gap between them.
module uart_buffered_transmitter #(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int DATA_WIDTH      = 8,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic                             uart_transmit,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int TIMER_W        = $clog2(CLOCKS_PER_BIT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W          = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Odd mode makes data+parity carry an odd number of ones, even mode an even number.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
    return (PARITY_MODE == 1) ? ~(^d) : (^d);
  endfunction

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push, pop, empty;
  logic [DATA_WIDTH-1:0] head;

  state_t                state, state_next;
  logic [TIMER_W-1:0]    timer, timer_next;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
  logic                  line_next, bit_end;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  par, par_next;

  assign data_in_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign empty         = (fifo_count == '0);
  assign push          = data_in_valid & data_in_ready;
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) | ~empty;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      uart_transmit <= 1'b1;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      bit_cnt       <= bit_cnt_next;
      uart_transmit <= line_next;
    end
  end

  always_ff @(posedge clock) begin
    shift <= shift_next;
    par   <= par_next;
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    line_next    = uart_transmit;
    shift_next   = shift;
    par_next     = par;
    pop          = 1'b0;
    bit_end      = (timer == TIMER_W'(CLOCKS_PER_BIT - 1));
    timer_next   = bit_end ? '0 : timer + 1'b1;
    case (state)
      IDLE: begin
        timer_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = parity_of(head);
          line_next  = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          line_next    = shift[0];
          shift_next   = shift >> 1;
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            if (PARITY_MODE != 0) begin
              line_next  = par;
              state_next = PARITY;
            end else begin
              line_next  = 1'b1;
              state_next = STOP;
            end
          end else begin
            line_next    = shift[0];
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          line_next    = 1'b1;
          bit_cnt_next = '0;
          state_next   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            bit_cnt_next = '0;
            // Chain straight into the next start bit when more data is queued.
            if (!empty) begin
              pop        = 1'b1;
              shift_next = head;
              par_next   = parity_of(head);
              line_next  = 1'b0;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Bench for uart_buffered_transmitter: four instances (8N1 deep, 8N1 shallow,
// 7E2, 7O2) checked against an ideal per-cycle line model built from frame rules.
module tb_uart_buffered_transmitter;
  localparam int CPB = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_a, rst_o;
  logic [7:0] din_a, din_b;
  logic [6:0] din_c, din_d;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic [4:0] cnt_a, cnt_c, cnt_d;
  logic [2:0] cnt_b;

  int checks = 0;
  int passed = 0;
  logic cap  [0:2047];
  logic capb [0:2047];

  uart_buffered_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_WIDTH(8),
    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
    .clock(clock), .reset(rst_a), .data_in(din_a), .data_in_valid(vld_a),
    .data_in_ready(rdy_a), .uart_transmit(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_buffered_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_WIDTH(8),
    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clock(clock), .reset(rst_o), .data_in(din_b), .data_in_valid(vld_b),
    .data_in_ready(rdy_b), .uart_transmit(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  uart_buffered_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_WIDTH(7),
    .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
    .clock(clock), .reset(rst_o), .data_in(din_c), .data_in_valid(vld_c),
    .data_in_ready(rdy_c), .uart_transmit(tx_c), .busy(busy_c), .fifo_count(cnt_c));

  uart_buffered_transmitter #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .DATA_WIDTH(7),
    .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(16)) dut_d (
    .clock(clock), .reset(rst_o), .data_in(din_d), .data_in_valid(vld_d),
    .data_in_ready(rdy_d), .uart_transmit(tx_d), .busy(busy_d), .fifo_count(cnt_d));

  function automatic logic line_of(input int w);
    case (w)
      0: return tx_a;
      1: return tx_b;
      2: return tx_c;
      default: return tx_d;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  function automatic int frame_len(input int dw, input int pm, input int sb);
    return (1 + dw + ((pm != 0) ? 1 : 0) + sb) * CPB;
  endfunction

  // Ideal line waveform: list the frame's bits, then hold each for CPB cycles.
  function automatic logic [127:0] exp_frame(input int data, input int dw, input int pm, input int sb);
    logic [127:0] v;
    int bits[$];
    int ones;
    int pos;
    v = '0;
    ones = 0;
    pos = 0;
    bits.push_back(0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back((data >> i) & 1);
      ones += (data >> i) & 1;
    end
    if (pm == 1) bits.push_back((ones % 2 == 0) ? 1 : 0);
    else if (pm == 2) bits.push_back(ones % 2);
    for (int i = 0; i < sb; i++) bits.push_back(1);
    foreach (bits[k]) begin
      for (int c = 0; c < CPB; c++) begin
        v[pos] = bits[k][0];
        pos++;
      end
    end
    return v;
  endfunction

  function automatic logic [127:0] slice(input int base, input int len);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[i] = cap[base + i];
    return v;
  endfunction

  task automatic capture(input int w, input int n, input int timeout, output bit found);
    found = 1'b0;
    for (int k = 0; k < timeout; k++) begin
      @(negedge clock);
      if (line_of(w) == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      cap[0]  = 1'b0;
      capb[0] = busy_of(w);
      for (int i = 1; i < n; i++) begin
        @(negedge clock);
        cap[i]  = line_of(w);
        capb[i] = busy_of(w);
      end
    end
  endtask

  task automatic push(input int w, input logic [8:0] d);
    case (w)
      0: begin din_a = d[7:0]; vld_a = 1'b1; end
      1: begin din_b = d[7:0]; vld_b = 1'b1; end
      2: begin din_c = d[6:0]; vld_c = 1'b1; end
      default: begin din_d = d[6:0]; vld_d = 1'b1; end
    endcase
    @(posedge clock); #1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0; vld_d = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_o = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    din_a = 8'hA5; vld_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      checks++; if (cnt_a !== 5'd0) $display("FAIL reset_hold_count[%0d]: got %0d expected 0", i, cnt_a); else passed++;
      checks++; if (tx_a !== 1'b1) $display("FAIL reset_hold_line[%0d]: got %b expected 1", i, tx_a); else passed++;
    end
    @(posedge clock); #1;
    vld_a = 1'b0; rst_a = 1'b0; rst_o = 1'b0;
    @(negedge clock);
    checks++; if (rdy_a !== 1'b1) $display("FAIL reset_ready: got %b expected 1", rdy_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_a); else passed++;
    checks++; if (cnt_a !== 5'd0) $display("FAIL reset_count: got %0d expected 0", cnt_a); else passed++;
    checks++; if ({tx_a, tx_b, tx_c, tx_d} !== 4'b1111) $display("FAIL reset_lines: got %b expected 1111", {tx_a, tx_b, tx_c, tx_d}); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_single_frame();
    bit found;
    logic [127:0] obs, exp;
    push(0, 9'h048);
    @(negedge clock);
    checks++; if (tx_a !== 1'b1) $display("FAIL single_prestart_line: got %b expected 1", tx_a); else passed++;
    checks++; if (busy_a !== 1'b1) $display("FAIL single_queued_busy: got %b expected 1", busy_a); else passed++;
    capture(0, 100, 1, found);
    checks++; if (found !== 1'b1) $display("FAIL single_start_edge: got %b expected 1", found); else passed++;
    obs = slice(0, 100);
    exp = exp_frame(32'h48, 8, 0, 1);
    checks++; if (obs !== exp) $display("FAIL single_frame: got %h expected %h", obs, exp); else passed++;
    checks++; if (capb[99] !== 1'b1) $display("FAIL single_busy_last: got %b expected 1", capb[99]); else passed++;
    @(negedge clock);
    checks++; if (busy_a !== 1'b0) $display("FAIL single_busy_end: got %b expected 0", busy_a); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_contiguous();
    logic [7:0] msg [15];
    int drops;
    bit found;
    logic [127:0] obs, exp;
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6C, 8'h6C, 8'h6F, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    drops = 0;
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          din_a = msg[i]; vld_a = 1'b1;
          if (rdy_a !== 1'b1) drops++;
          @(posedge clock); #1;
        end
        vld_a = 1'b0;
      end
      capture(0, 1500, 30, found);
    join
    checks++; if (drops !== 0) $display("FAIL contig_ready_drops: got %0d expected 0", drops); else passed++;
    checks++; if (found !== 1'b1) $display("FAIL contig_start: got %b expected 1", found); else passed++;
    for (int k = 0; k < 15; k++) begin
      obs = slice(k * 100, 100);
      exp = exp_frame(int'(msg[k]), 8, 0, 1);
      checks++; if (obs !== exp) $display("FAIL contig_frame%0d: got %h expected %h", k, obs, exp); else passed++;
    end
    @(negedge clock);
    checks++; if (busy_a !== 1'b0) $display("FAIL contig_busy_end: got %b expected 0", busy_a); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes [8];
    int acc_edge [8];
    int n_acc, j, full_viol, early, flen;
    bit saw_full_low, found, dup, acc;
    logic [127:0] obs, exp;
    flen = frame_len(8, 0, 1);
    for (int i = 0; i < 8; i++) begin
      acc_edge[i] = 0;
      do begin
        bytes[i] = 8'($urandom);
        dup = 1'b0;
        for (int k = 0; k < i; k++) if (bytes[k] == bytes[i]) dup = 1'b1;
      end while (dup);
    end
    n_acc = 0; j = 0; full_viol = 0; saw_full_low = 1'b0;
    fork
      begin
        while (n_acc < 8 && j < 2000) begin
          din_b = bytes[n_acc]; vld_b = 1'b1;
          @(negedge clock);
          acc = rdy_b;
          if (cnt_b == 3'd4) begin
            if (rdy_b) full_viol++;
            else saw_full_low = 1'b1;
          end
          @(posedge clock); #1;
          if (acc) begin
            acc_edge[n_acc] = j;
            n_acc++;
          end
          j++;
        end
        vld_b = 1'b0;
      end
      capture(1, 800, 30, found);
    join
    checks++; if (n_acc !== 8) $display("FAIL full_accepted: got %0d expected 8", n_acc); else passed++;
    checks++; if (saw_full_low !== 1'b1) $display("FAIL full_ready_low: got %b expected 1", saw_full_low); else passed++;
    checks++; if (full_viol !== 0) $display("FAIL full_ready_when_full: got %0d expected 0", full_viol); else passed++;
    early = 0;
    // First frame starts after edge index 1 and ends one frame length later.
    for (int k = 0; k < 8; k++) if (acc_edge[k] <= 1 + flen) early++;
    checks++; if (early !== 5) $display("FAIL full_early_accepts: got %0d expected 5", early); else passed++;
    for (int k = 6; k < 8; k++) begin
      checks++; if (acc_edge[k] - acc_edge[k-1] !== flen) $display("FAIL full_gap%0d: got %0d expected %0d", k, acc_edge[k] - acc_edge[k-1], flen); else passed++;
    end
    checks++; if (found !== 1'b1) $display("FAIL full_start: got %b expected 1", found); else passed++;
    for (int k = 0; k < 8; k++) begin
      obs = slice(k * 100, 100);
      exp = exp_frame(int'(bytes[k]), 8, 0, 1);
      checks++; if (obs !== exp) $display("FAIL full_frame%0d: got %h expected %h", k, obs, exp); else passed++;
    end
    @(negedge clock);
    checks++; if (busy_b !== 1'b0) $display("FAIL full_busy_end: got %b expected 0", busy_b); else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_parity();
    int inst [9];
    int data [9];
    int pbit [3];
    int pm, len;
    bit found;
    logic [127:0] obs, exp;
    inst = '{2, 3, 2, 2, 3, 2, 3, 2, 3};
    data = '{32'h55, 32'h55, 32'h54, 0, 0, 0, 0, 0, 0};
    pbit = '{0, 1, 1};
    for (int i = 3; i < 9; i++) data[i] = int'($urandom_range(0, 127));
    for (int i = 0; i < 9; i++) begin
      pm = (inst[i] == 2) ? 2 : 1;
      len = frame_len(7, pm, 2);
      push(inst[i], 9'(data[i]));
      capture(inst[i], len, 5, found);
      checks++; if (found !== 1'b1) $display("FAIL parity_start%0d: got %b expected 1", i, found); else passed++;
      obs = slice(0, len);
      exp = exp_frame(data[i], 7, pm, 2);
      checks++; if (obs !== exp) $display("FAIL parity_frame%0d: got %h expected %h", i, obs, exp); else passed++;
      if (i < 3) begin
        checks++; if (cap[8 * CPB + CPB / 2] !== pbit[i][0]) $display("FAIL parity_bit%0d: got %b expected %0d", i, cap[8 * CPB + CPB / 2], pbit[i]); else passed++;
        checks++; if (capb[len - 1] !== 1'b1) $display("FAIL parity_busy_last%0d: got %b expected 1", i, capb[len - 1]); else passed++;
      end
      @(negedge clock);
      checks++; if (busy_of(inst[i]) !== 1'b0) $display("FAIL parity_busy_end%0d: got %b expected 0", i, busy_of(inst[i])); else passed++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b [3];
    logic [7:0] fresh;
    int quiet_bad;
    bit found;
    logic [127:0] obs, exp;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) push(0, {1'b0, b[i]});
    repeat (42) @(posedge clock);
    @(negedge clock);
    checks++; if (tx_a !== b[0][3]) $display("FAIL mid_bit3: got %b expected %b", tx_a, b[0][3]); else passed++;
    @(posedge clock); #1;
    rst_a = 1'b1;
    @(posedge clock); #1;
    rst_a = 1'b0;
    @(negedge clock);
    checks++; if (tx_a !== 1'b1) $display("FAIL mid_reset_line: got %b expected 1", tx_a); else passed++;
    checks++; if (busy_a !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy_a); else passed++;
    checks++; if (cnt_a !== 5'd0) $display("FAIL mid_reset_count: got %0d expected 0", cnt_a); else passed++;
    quiet_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) quiet_bad++;
    end
    checks++; if (quiet_bad !== 0) $display("FAIL mid_no_frames: got %0d active cycles expected 0", quiet_bad); else passed++;
    @(posedge clock); #1;
    fresh = 8'($urandom);
    push(0, {1'b0, fresh});
    capture(0, 100, 5, found);
    checks++; if (found !== 1'b1) $display("FAIL mid_fresh_start: got %b expected 1", found); else passed++;
    obs = slice(0, 100);
    exp = exp_frame(int'(fresh), 8, 0, 1);
    checks++; if (obs !== exp) $display("FAIL mid_fresh_frame: got %h expected %h", obs, exp); else passed++;
    @(negedge clock);
    checks++; if (busy_a !== 1'b0) $display("FAIL mid_fresh_busy_end: got %b expected 0", busy_a); else passed++;
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_o = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0; vld_d = 1'b0;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0;
    test_reset();
    test_single_frame();
    test_contiguous();
    test_fifo_full();
    test_parity();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
